// File: rtl/bcd_cascade_counter_if.sv
// Control and data bundle for the cascaded BCD counter.
// master drives controls and parallel data; slave is the counter.
interface bcd_cascade_counter_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   din;
   logic [4*DIGITS-1:0]   q;
   logic                  co;
   logic                  wrapped;
   logic                  load_err;

   modport master (
      output en, up, load, din,
      input  q, co, wrapped, load_err
   );

   modport slave (
      input  en, up, load, din,
      output q, co, wrapped, load_err
   );
endinterface

// File: rtl/bcd_cascade_counter.sv
// Cascaded up/down BCD counter with validated parallel load,
// wrap or saturate at terminal count, and carry/borrow out.
module bcd_cascade_counter #(
   parameter int DIGITS = 4,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  clk,
   input  logic                  clr,
   bcd_cascade_counter_if.slave  bus
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] r_q;
   logic         r_wrapped;
   logic         r_load_err;

   logic [W-1:0] w_step;
   logic         w_term;
   logic         w_din_ok;

   // One step in the current direction; ripple ends with w_term
   // high only when every digit rolled, i.e. terminal count.
   always_comb begin
      w_step = r_q;
      w_term = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_term) begin
            if (bus.up) begin
               if (r_q[4*k +: 4] == 4'd9) begin
                  w_step[4*k +: 4] = 4'd0;
               end else begin
                  w_step[4*k +: 4] = r_q[4*k +: 4] + 4'd1;
                  w_term = 1'b0;
               end
            end else begin
               if (r_q[4*k +: 4] == 4'd0) begin
                  w_step[4*k +: 4] = 4'd9;
               end else begin
                  w_step[4*k +: 4] = r_q[4*k +: 4] - 4'd1;
                  w_term = 1'b0;
               end
            end
         end
      end
   end

   // A load is only accepted if every digit of din is a BCD digit.
   always_comb begin
      w_din_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (bus.din[4*k +: 4] > 4'd9) begin
            w_din_ok = 1'b0;
         end
      end
   end

   assign bus.co = bus.en & ~bus.load & w_term;

   // Count register: clr, then load, then enable; flags pulse one cycle.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_q        <= '0;
         r_wrapped  <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_wrapped  <= 1'b0;
         r_load_err <= 1'b0;
         if (bus.load) begin
            if (w_din_ok) begin
               r_q <= bus.din;
            end else begin
               r_load_err <= 1'b1;
            end
         end else if (bus.en) begin
            if (w_term) begin
               r_wrapped <= 1'b1;
            end
            if (!w_term || WRAP) begin
               r_q <= w_step;
            end
         end
      end
   end

   assign bus.q        = r_q;
   assign bus.wrapped  = r_wrapped;
   assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Scoreboard bench: one wrapping and one saturating counter
// driven in lockstep against a decimal reference model.
module tb_bcd_cascade_counter;

   logic clk;
   logic clr;

   bcd_cascade_counter_if #(.DIGITS(4)) bus_w ();
   bcd_cascade_counter_if #(.DIGITS(4)) bus_s ();

   bcd_cascade_counter #(.DIGITS(4), .WRAP(1'b1)) dut_w (
      .clk (clk),
      .clr (clr),
      .bus (bus_w)
   );

   bcd_cascade_counter #(.DIGITS(4), .WRAP(1'b0)) dut_s (
      .clk (clk),
      .clr (clr),
      .bus (bus_s)
   );

   typedef struct {
      string       tag;
      logic [15:0] qw;
      logic        ww;
      logic        lw;
      logic [15:0] qs;
      logic        ws;
      logic        ls;
   } exp_t;

   exp_t exp_q[$];

   int n_chk = 0;
   int n_err = 0;

   int m_w;
   int m_s;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int from_bcd(input logic [15:0] b);
      int r;
      r = 0;
      for (int k = 3; k >= 0; k--) begin
         r = r * 10 + int'(b[4*k +: 4]);
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [15:0] b);
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (b[4*k +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic model(input bit wrap, input bit en, input bit up,
                        input bit ld, input logic [15:0] din,
                        inout int m, output logic wr, output logic le);
      wr = 1'b0;
      le = 1'b0;
      if (ld) begin
         if (bcd_ok(din)) m = from_bcd(din);
         else le = 1'b1;
      end else if (en) begin
         if (up) begin
            if (m == 9999) begin
               wr = 1'b1;
               if (wrap) m = 0;
            end else begin
               m = m + 1;
            end
         end else begin
            if (m == 0) begin
               wr = 1'b1;
               if (wrap) m = 9999;
            end else begin
               m = m - 1;
            end
         end
      end
   endtask

   function automatic logic co_of(input bit en, input bit up,
                                  input bit ld, input int m);
      return en & ~ld & (up ? (m == 9999) : (m == 0));
   endfunction

   task automatic set_in(input bit en, input bit up,
                         input bit ld, input logic [15:0] din);
      bus_w.en = en;  bus_w.up = up;
      bus_w.load = ld; bus_w.din = din;
      bus_s.en = en;  bus_s.up = up;
      bus_s.load = ld; bus_s.din = din;
   endtask

   task automatic drive(input string tag, input bit en, input bit up,
                        input bit ld, input logic [15:0] din);
      exp_t e;
      exp_t g;
      set_in(en, up, ld, din);
      #1;
      chk({tag, ".co_w"}, 32'(bus_w.co), 32'(co_of(en, up, ld, m_w)));
      chk({tag, ".co_s"}, 32'(bus_s.co), 32'(co_of(en, up, ld, m_s)));
      e.tag = tag;
      model(1'b1, en, up, ld, din, m_w, e.ww, e.lw);
      model(1'b0, en, up, ld, din, m_s, e.ws, e.ls);
      e.qw = to_bcd(m_w);
      e.qs = to_bcd(m_s);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         g = exp_q.pop_front();
         chk({g.tag, ".q_w"},  32'(bus_w.q),        32'(g.qw));
         chk({g.tag, ".wr_w"}, 32'(bus_w.wrapped),  32'(g.ww));
         chk({g.tag, ".le_w"}, 32'(bus_w.load_err), 32'(g.lw));
         chk({g.tag, ".q_s"},  32'(bus_s.q),        32'(g.qs));
         chk({g.tag, ".wr_s"}, 32'(bus_s.wrapped),  32'(g.ws));
         chk({g.tag, ".le_s"}, 32'(bus_s.load_err), 32'(g.ls));
      end
   endtask

   initial begin
      logic [15:0] rd;
      m_w = 0;
      m_s = 0;

      clr = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 16'h1234);
      #3;
      chk("rst.q_w", 32'(bus_w.q), 32'h0);
      chk("rst.wr_w", 32'(bus_w.wrapped), 32'h0);
      chk("rst.le_w", 32'(bus_w.load_err), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_hold.q_w", 32'(bus_w.q), 32'h0);
      chk("rst_hold.q_s", 32'(bus_s.q), 32'h0);
      #2;
      clr = 1'b1;

      drive("dn0", 1'b1, 1'b0, 1'b0, 16'h0);
      drive("dn1", 1'b1, 1'b0, 1'b0, 16'h0);
      drive("dn2", 1'b1, 1'b0, 1'b0, 16'h0);

      drive("ld9998", 1'b0, 1'b1, 1'b1, 16'h9998);
      drive("up9999", 1'b1, 1'b1, 1'b0, 16'h0);
      drive("upwrap", 1'b1, 1'b1, 1'b0, 16'h0);
      drive("up0001", 1'b1, 1'b1, 1'b0, 16'h0);

      drive("ld9999", 1'b0, 1'b1, 1'b1, 16'h9999);
      for (int i = 0; i < 3; i++) drive("sat", 1'b1, 1'b1, 1'b0, 16'h0);

      drive("ldbad", 1'b0, 1'b1, 1'b1, 16'h12A4);
      drive("ldgood", 1'b0, 1'b1, 1'b1, 16'h1234);
      drive("hold", 1'b0, 1'b1, 1'b0, 16'h0);

      drive("ld_en", 1'b1, 1'b1, 1'b1, 16'h0500);
      drive("ld0099", 1'b0, 1'b1, 1'b1, 16'h0099);
      drive("casc_up", 1'b1, 1'b1, 1'b0, 16'h0);
      drive("casc_dn", 1'b1, 1'b0, 1'b0, 16'h0);
      drive("dir_up", 1'b1, 1'b1, 1'b0, 16'h0);
      drive("dir_dn", 1'b1, 1'b0, 1'b0, 16'h0);

      drive("ld0000", 1'b0, 1'b0, 1'b1, 16'h0000);
      drive("lowrap", 1'b1, 1'b0, 1'b0, 16'h0);

      for (int i = 0; i < 60; i++) begin
         rd = 16'($urandom);
         if ($urandom_range(0, 1) == 0) rd = to_bcd($urandom_range(0, 9999));
         if ($urandom_range(0, 1) == 0) rd = 16'h9995 + 16'($urandom_range(0, 4));
         drive("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom),
               1'($urandom_range(0, 5) == 0), rd);
      end

      drive("ld4567", 1'b0, 1'b1, 1'b1, 16'h4567);
      drive("cnt", 1'b1, 1'b1, 1'b0, 16'h0);
      set_in(1'b1, 1'b1, 1'b0, 16'h0);
      #3;
      clr = 1'b0;
      #1;
      chk("aclr.q_w", 32'(bus_w.q), 32'h0);
      chk("aclr.q_s", 32'(bus_s.q), 32'h0);
      chk("aclr.wr_w", 32'(bus_w.wrapped), 32'h0);
      chk("aclr.le_w", 32'(bus_w.load_err), 32'h0);
      m_w = 0;
      m_s = 0;
      #1;
      clr = 1'b1;
      drive("resume1", 1'b1, 1'b1, 1'b0, 16'h0);
      drive("resume2", 1'b1, 1'b1, 1'b0, 16'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bcd_cascade_counter.md
BCD_CASCADE_COUNTER -- requirements
Module: bcd_cascade_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded BCD digits, legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; count advances one step per clk edge while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 din  input  4*DIGITS  parallel load value, digit k in bits [4k+3:4k], digit 0 least significant.
REQ-009 q  output  4*DIGITS  registered count, same digit packing as din.
REQ-010 co  output  1  combinational carry/borrow out, for cascading further counters.
REQ-011 wrapped  output  1  registered one-cycle pulse on a terminal-count event.
REQ-012 load_err  output  1  registered one-cycle pulse on a rejected load.

Function
REQ-013 Each digit of q SHALL hold only values 0..9 at all times.
REQ-014 Priority per edge SHALL be: clr, then load, then en; load SHALL be honoured regardless of en.
REQ-015 Valid load SHALL set q = din on the same edge; latency 1 clk.
REQ-016 A load is invalid when any digit of din > 9; q SHALL hold, and load_err SHALL pulse high for exactly the next cycle.
REQ-017 When load=1 and the load is valid, load_err SHALL be 0, and wrapped SHALL be 0 for the next cycle.
REQ-018 Up count: digit k SHALL increment when en=1, and digits 0..k-1 SHALL all equal 9; a digit at 9 SHALL become 0.
REQ-019 Down count: digit k SHALL decrement when en=1, and digits 0..k-1 SHALL all equal 0; a digit at 0 SHALL become 9.
REQ-020 Terminal count SHALL be all digits 9 when up=1 and all digits 0 when up=0.
REQ-021 co SHALL equal en & ~load & (q at terminal count for the current up); it is purely combinational.
REQ-022 WRAP=1, en=1 at terminal: q SHALL go to all-0 (up) or all-9 (down), and wrapped SHALL pulse high for exactly the next cycle.
REQ-023 WRAP=0, en=1 at terminal: q SHALL hold, and wrapped SHALL pulse high for exactly the next cycle.
REQ-024 en held at terminal in WRAP=0 SHALL produce a wrapped pulse on every edge, i.e. wrapped remains high.
REQ-025 Changing up between edges SHALL take effect on the next edge, with no lost or extra steps.
REQ-026 en=0 and load=0 SHALL hold q, and wrapped and load_err SHALL be 0.

Reset
REQ-027 clr=0 SHALL force q=0, wrapped=0 and load_err=0 immediately, independent of clk.
REQ-028 While clr=0, load and en SHALL be ignored.
REQ-029 After clr deasserts, the first active edge SHALL act normally.
REQ-030 Reset asserted mid-count or mid-load SHALL discard that operation.

Verification
REQ-031 DIGITS=4, WRAP=1, up=1, en=1, load 0x9998 -> q: 9999 (co=1), then 0000 with wrapped=1 for one cycle, then 0001.
REQ-032 DIGITS=4, WRAP=1, up=0, en=1 from reset -> q: 9999 on the first edge, wrapped=1 the next cycle; co=1 while q=0000 and en=1.
REQ-033 WRAP=0, up=1, q=9999, en=1 for 3 edges -> q stays 9999, wrapped stays high, no digit exceeds 9.
REQ-034 load=1, din=0x12A4 -> q unchanged, load_err=1 for one cycle; then load=1, din=0x1234 -> q=1234, load_err=0.
REQ-035 load=1, en=1, up=1, din=0x0500 -> q=0500, not 0501; cascade check: q=0099 up -> 0100, q=0100 down -> 0099.
REQ-036 clr pulsed low asynchronously between edges while q=4567 and counting -> q=0000 immediately; counting resumes from 0000 after release.
